// File: rtl/jtframe_video_timer_pkg.sv
// Shared types and default raster timing for the video timer.
package jtframe_video_timer_pkg;

    // Default 384x262 raster
    localparam int unsigned DefHcntW   = 9;
    localparam int unsigned DefVcntW   = 9;
    localparam int unsigned DefHTotal  = 384;
    localparam int unsigned DefHbStart = 256;
    localparam int unsigned DefHbEnd   = 0;
    localparam int unsigned DefHsStart = 296;
    localparam int unsigned DefHsEnd   = 328;
    localparam int unsigned DefVTotal  = 262;
    localparam int unsigned DefVbStart = 240;
    localparam int unsigned DefVbEnd   = 16;
    localparam int unsigned DefVsStart = 244;
    localparam int unsigned DefVsEnd   = 247;

    // Registered per-pixel flags, kept together so they stay aligned with H/V
    typedef struct packed {
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
        logic hinit;
        logic vinit;
        logic field;
    } vt_flags_t;

    localparam vt_flags_t VtFlagsRst = '{
        lhbl:  1'b1,
        lvbl:  1'b0,
        hs:    1'b0,
        vs:    1'b0,
        hinit: 1'b1,
        vinit: 1'b1,
        field: 1'b0
    };

    // True when a counter of the given width can hold total distinct values
    function automatic logic vt_fits(int unsigned total, int unsigned width);
        return 64'(total) <= (64'd1 << width);
    endfunction

endpackage

// File: rtl/jtframe_video_timer_if.sv
// Raster timing bundle: pixel enable in, counters and flags out.
interface jtframe_video_timer_if #(
    parameter int unsigned HCNT_W = 9,
    parameter int unsigned VCNT_W = 9
) ();

    logic              pxl_cen;
    logic [HCNT_W-1:0] H;
    logic [VCNT_W-1:0] V;
    logic              LHBL;
    logic              LVBL;
    logic              hs;
    logic              vs;
    logic              hinit;
    logic              vinit;
    logic              field;

    // Timer side
    modport master (
        input  pxl_cen,
        output H, V, LHBL, LVBL, hs, vs, hinit, vinit, field
    );

    // Consumer side (pixel clock source and downstream video logic)
    modport slave (
        output pxl_cen,
        input  H, V, LHBL, LVBL, hs, vs, hinit, vinit, field
    );

endinterface

// File: rtl/jtframe_video_timer.vh
// Timing presets for jtframe_video_timer. A core defines JTFRAME_VT_320X264 before
// including this header to pick the narrower raster; otherwise the 384x262 set is used.
// The macros are meant to be passed straight into the timer's parameter list.
`ifndef JTFRAME_VIDEO_TIMER_VH
`define JTFRAME_VIDEO_TIMER_VH

`ifdef JTFRAME_VT_320X264
    `define JTFRAME_VT_HCNT_W    9
    `define JTFRAME_VT_VCNT_W    9
    `define JTFRAME_VT_H_TOTAL   320
    `define JTFRAME_VT_HB_START  256
    `define JTFRAME_VT_HB_END    0
    `define JTFRAME_VT_HS_START  272
    `define JTFRAME_VT_HS_END    296
    `define JTFRAME_VT_V_TOTAL   264
    `define JTFRAME_VT_VB_START  240
    `define JTFRAME_VT_VB_END    16
    `define JTFRAME_VT_VS_START  244
    `define JTFRAME_VT_VS_END    247
`else
    `define JTFRAME_VT_HCNT_W    9
    `define JTFRAME_VT_VCNT_W    9
    `define JTFRAME_VT_H_TOTAL   384
    `define JTFRAME_VT_HB_START  256
    `define JTFRAME_VT_HB_END    0
    `define JTFRAME_VT_HS_START  296
    `define JTFRAME_VT_HS_END    328
    `define JTFRAME_VT_V_TOTAL   262
    `define JTFRAME_VT_VB_START  240
    `define JTFRAME_VT_VB_END    16
    `define JTFRAME_VT_VS_START  244
    `define JTFRAME_VT_VS_END    247
`endif

`endif

// File: rtl/jtframe_video_timer_win.sv
// Combinational wrap-aware window test: inside when x is in [start, end),
// wrapping through zero when start >= end.
module jtframe_video_timer_win #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] end_i,
    output logic         inside_o
);

    // Plain interval when ordered, union of the two tails when wrapped
    always_comb begin
        if (start_i < end_i) begin
            inside_o = (x_i >= start_i) && (x_i < end_i);
        end else begin
            inside_o = (x_i >= start_i) || (x_i < end_i);
        end
    end

endmodule

// File: rtl/jtframe_video_timer.sv
// Free-running raster timing generator. Counters advance on pxl_cen and every flag is
// derived from the upcoming H/V, so the registered outputs always describe the H/V
// they are presented with.
module jtframe_video_timer
    import jtframe_video_timer_pkg::*;
#(
    parameter int unsigned HCNT_W   = DefHcntW,
    parameter int unsigned VCNT_W   = DefVcntW,
    parameter int unsigned H_TOTAL  = DefHTotal,
    parameter int unsigned HB_START = DefHbStart,
    parameter int unsigned HB_END   = DefHbEnd,
    parameter int unsigned HS_START = DefHsStart,
    parameter int unsigned HS_END   = DefHsEnd,
    parameter int unsigned V_TOTAL  = DefVTotal,
    parameter int unsigned VB_START = DefVbStart,
    parameter int unsigned VB_END   = DefVbEnd,
    parameter int unsigned VS_START = DefVsStart,
    parameter int unsigned VS_END   = DefVsEnd
) (
    input logic                  clk,
    input logic                  rst_n,
    jtframe_video_timer_if.master vid
);

    localparam logic [HCNT_W-1:0] HLast   = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] HbStart = HCNT_W'(HB_START);
    localparam logic [HCNT_W-1:0] HbEnd   = HCNT_W'(HB_END);
    localparam logic [HCNT_W-1:0] HsStart = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] HsEnd   = HCNT_W'(HS_END);
    localparam logic [VCNT_W-1:0] VLast   = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] VbStart = VCNT_W'(VB_START);
    localparam logic [VCNT_W-1:0] VbEnd   = VCNT_W'(VB_END);
    localparam logic [VCNT_W-1:0] VsStart = VCNT_W'(VS_START);
    localparam logic [VCNT_W-1:0] VsEnd   = VCNT_W'(VS_END);

    logic [HCNT_W-1:0] h_q, h_d, h_nx;
    logic [VCNT_W-1:0] v_q, v_d, v_nx;
    logic              h_wrap;
    vt_flags_t         flags_q, flags_d, flags_nx;
    logic              hb_in, hs_in, vb_in;

`ifdef SIMULATION
    // Reject timing sets the counters cannot represent
    initial begin
        if (HB_START >= H_TOTAL || HB_END >= H_TOTAL ||
            HS_START >= H_TOTAL || HS_END >= H_TOTAL) begin
            $display("jtframe_video_timer: H timing parameter not below H_TOTAL");
            $finish;
        end
        if (VB_START >= V_TOTAL || VB_END >= V_TOTAL ||
            VS_START >= V_TOTAL || VS_END >= V_TOTAL) begin
            $display("jtframe_video_timer: V timing parameter not below V_TOTAL");
            $finish;
        end
        if (!vt_fits(H_TOTAL, HCNT_W) || !vt_fits(V_TOTAL, VCNT_W)) begin
            $display("jtframe_video_timer: counter width too small for totals");
            $finish;
        end
        if (HS_START == HS_END) begin
            $display("jtframe_video_timer: HS_START equals HS_END");
            $finish;
        end
    end
`endif

    // Counter values that the next pxl_cen will present
    always_comb begin
        h_wrap = (h_q == HLast);
        h_nx   = h_wrap ? '0 : h_q + HCNT_W'(1);
        v_nx   = v_q;
        if (h_wrap) begin
            v_nx = (v_q == VLast) ? '0 : v_q + VCNT_W'(1);
        end
    end

    jtframe_video_timer_win #(
        .W (HCNT_W)
    ) u_hb_win (
        .x_i      (h_nx),
        .start_i  (HbStart),
        .end_i    (HbEnd),
        .inside_o (hb_in)
    );

    jtframe_video_timer_win #(
        .W (HCNT_W)
    ) u_hs_win (
        .x_i      (h_nx),
        .start_i  (HsStart),
        .end_i    (HsEnd),
        .inside_o (hs_in)
    );

    jtframe_video_timer_win #(
        .W (VCNT_W)
    ) u_vb_win (
        .x_i      (v_nx),
        .start_i  (VbStart),
        .end_i    (VbEnd),
        .inside_o (vb_in)
    );

    // Flags that go with the upcoming H/V; vs only moves on the hs leading pixel
    always_comb begin
        flags_nx       = flags_q;
        flags_nx.lhbl  = ~hb_in;
        flags_nx.lvbl  = ~vb_in;
        flags_nx.hs    = hs_in;
        flags_nx.hinit = (h_nx == '0);
        flags_nx.vinit = flags_nx.hinit && (v_nx == '0);
        flags_nx.field = flags_q.field ^ flags_nx.vinit;
        if (h_nx == HsStart) begin
            // Clear is checked first so VS_START == VS_END never asserts vs
            if (v_nx == VsEnd) begin
                flags_nx.vs = 1'b0;
            end else if (v_nx == VsStart) begin
                flags_nx.vs = 1'b1;
            end
        end
    end

    // Advance only on pixel enable, otherwise hold everything
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        flags_d = flags_q;
        if (vid.pxl_cen) begin
            h_d     = h_nx;
            v_d     = v_nx;
            flags_d = flags_nx;
        end
    end

    // State registers with synchronous reset taking priority over pxl_cen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            flags_q <= VtFlagsRst;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            flags_q <= flags_d;
        end
    end

    assign vid.H     = h_q;
    assign vid.V     = v_q;
    assign vid.LHBL  = flags_q.lhbl;
    assign vid.LVBL  = flags_q.lvbl;
    assign vid.hs    = flags_q.hs;
    assign vid.vs    = flags_q.vs;
    assign vid.hinit = flags_q.hinit;
    assign vid.vinit = flags_q.vinit;
    assign vid.field = flags_q.field;

endmodule

// File: tb/tb_jtframe_video_timer.sv
// Bench for jtframe_video_timer. Three instances: A is a small wrapping raster used for
// frame-level and randomized runs, B uses the default 384x262 timing, C has a
// non-wrapping horizontal blank and coincident vs start/end lines.
// The reference model maps the number of pixel enables since reset onto the raster
// with plain modular arithmetic.
module tb_jtframe_video_timer;

    typedef struct packed {
        int ht; int hbs; int hbe; int hss; int hse;
        int vt; int vbs; int vbe; int vss; int vse;
    } tim_t;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        lhbl;
        logic        lvbl;
        logic        hs;
        logic        vs;
        logic        hinit;
        logic        vinit;
        logic        field;
    } obs_t;

    localparam tim_t TA = '{ht: 40, hbs: 28, hbe: 4, hss: 31, hse: 35,
                            vt: 14, vbs: 10, vbe: 2, vss: 11, vse: 13};
    localparam tim_t TB = '{ht: 384, hbs: 256, hbe: 0, hss: 296, hse: 328,
                            vt: 262, vbs: 240, vbe: 16, vss: 244, vse: 247};
    localparam tim_t TC = '{ht: 48, hbs: 8, hbe: 40, hss: 42, hse: 46,
                            vt: 6, vbs: 4, vbe: 1, vss: 3, vse: 3};

    localparam obs_t RstObs = '{h: 16'd0, v: 16'd0, lhbl: 1'b1, lvbl: 1'b0, hs: 1'b0,
                                vs: 1'b0, hinit: 1'b1, vinit: 1'b1, field: 1'b0};

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   failures = 0;
    int   na = 0, nb = 0, nc = 0;

    always #5 clk = ~clk;

    jtframe_video_timer_if #(.HCNT_W(6), .VCNT_W(4)) ifa ();
    jtframe_video_timer_if #(.HCNT_W(9), .VCNT_W(9)) ifb ();
    jtframe_video_timer_if #(.HCNT_W(6), .VCNT_W(3)) ifc ();

    jtframe_video_timer #(
        .HCNT_W(6), .VCNT_W(4), .H_TOTAL(40), .HB_START(28), .HB_END(4),
        .HS_START(31), .HS_END(35), .V_TOTAL(14), .VB_START(10), .VB_END(2),
        .VS_START(11), .VS_END(13)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .vid   (ifa)
    );

    jtframe_video_timer dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .vid   (ifb)
    );

    jtframe_video_timer #(
        .HCNT_W(6), .VCNT_W(3), .H_TOTAL(48), .HB_START(8), .HB_END(40),
        .HS_START(42), .HS_END(46), .V_TOTAL(6), .VB_START(4), .VB_END(1),
        .VS_START(3), .VS_END(3)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_c),
        .vid   (ifc)
    );

    // Membership of x in [s, e) on a ring of size t; s == e covers the whole ring
    function automatic bit in_win(int x, int s, int e, int t);
        if (s == e) return 1'b1;
        return ((x - s + t) % t) < ((e - s + t) % t);
    endfunction

    // Expected outputs after n pixel enables since reset release
    function automatic obs_t model(tim_t t, int n);
        obs_t o;
        int frame, pos, h, v, vs0, vs1;
        if (n == 0) return RstObs;
        frame   = t.ht * t.vt;
        pos     = n % frame;
        h       = pos % t.ht;
        v       = pos / t.ht;
        vs0     = t.vss * t.ht + t.hss;
        vs1     = t.vse * t.ht + t.hss;
        o.h     = 16'(h);
        o.v     = 16'(v);
        o.lhbl  = !in_win(h, t.hbs, t.hbe, t.ht);
        o.lvbl  = !in_win(v, t.vbs, t.vbe, t.vt);
        o.hs    = in_win(h, t.hss, t.hse, t.ht);
        o.vs    = (vs0 != vs1) && in_win(pos, vs0, vs1, frame);
        o.hinit = (h == 0);
        o.vinit = (pos == 0);
        o.field = ((n / frame) % 2) == 1;
        return o;
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o = '{h: 16'(ifa.H), v: 16'(ifa.V), lhbl: ifa.LHBL, lvbl: ifa.LVBL, hs: ifa.hs,
              vs: ifa.vs, hinit: ifa.hinit, vinit: ifa.vinit, field: ifa.field};
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o = '{h: 16'(ifb.H), v: 16'(ifb.V), lhbl: ifb.LHBL, lvbl: ifb.LVBL, hs: ifb.hs,
              vs: ifb.vs, hinit: ifb.hinit, vinit: ifb.vinit, field: ifb.field};
        return o;
    endfunction

    function automatic obs_t get_c();
        obs_t o;
        o = '{h: 16'(ifc.H), v: 16'(ifc.V), lhbl: ifc.LHBL, lvbl: ifc.LVBL, hs: ifc.hs,
              vs: ifc.vs, hinit: ifc.hinit, vinit: ifc.vinit, field: ifc.field};
        return o;
    endfunction

    // One clk edge; model positions follow the inputs that were applied at the edge
    task automatic tick();
        bit ca, cb, cc, ra, rb, rc;
        ca = ifa.pxl_cen; cb = ifb.pxl_cen; cc = ifc.pxl_cen;
        ra = rst_a; rb = rst_b; rc = rst_c;
        @(posedge clk);
        #1;
        if (!ra) na = 0; else if (ca) na++;
        if (!rb) nb = 0; else if (cb) nb++;
        if (!rc) nc = 0; else if (cc) nc++;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ifa.pxl_cen = 1'b1; ifb.pxl_cen = 1'b1; ifc.pxl_cen = 1'b1;
        repeat (3) tick();
        checks++;
        if (get_a() !== RstObs) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", get_a(), RstObs);
        end
        checks++;
        if (get_b() !== RstObs) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", get_b(), RstObs);
        end
        checks++;
        if (get_c() !== RstObs) begin
            failures++;
            $display("FAIL reset_c got=%h exp=%h", get_c(), RstObs);
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        checks++;
        if (ifa.H !== 6'd1 || ifa.V !== 4'd0 || ifa.hinit !== 1'b0) begin
            failures++;
            $display("FAIL first_cen_a got H=%0d V=%0d hinit=%b exp H=1 V=0 hinit=0",
                     ifa.H, ifa.V, ifa.hinit);
        end
        checks++;
        if (get_b() !== model(TB, nb)) begin
            failures++;
            $display("FAIL first_cen_b got=%h exp=%h", get_b(), model(TB, nb));
        end
        ifa.pxl_cen = 1'b0; ifb.pxl_cen = 1'b0; ifc.pxl_cen = 1'b0;
    endtask

    task automatic test_h_line();
        bit prev;
        int fall_h, rise_h, hs_cnt, hs_min, hs_max;
        fall_h = -1; rise_h = -1; hs_cnt = 0; hs_min = 9999; hs_max = -1;
        prev = ifb.LHBL;
        ifb.pxl_cen = 1'b1;
        repeat (384) begin
            tick();
            checks++;
            if (get_b() !== model(TB, nb)) begin
                failures++;
                $display("FAIL h_line n=%0d got=%h exp=%h", nb, get_b(), model(TB, nb));
            end
            if (prev && !ifb.LHBL) fall_h = int'(ifb.H);
            if (!prev && ifb.LHBL) rise_h = int'(ifb.H);
            prev = ifb.LHBL;
            if (ifb.hs) begin
                hs_cnt++;
                if (int'(ifb.H) < hs_min) hs_min = int'(ifb.H);
                if (int'(ifb.H) > hs_max) hs_max = int'(ifb.H);
            end
        end
        ifb.pxl_cen = 1'b0;
        checks++;
        if (fall_h != 256 || rise_h != 0) begin
            failures++;
            $display("FAIL lhbl_edges got fall=%0d rise=%0d exp fall=256 rise=0", fall_h, rise_h);
        end
        checks++;
        if (hs_cnt != 32 || hs_min != 296 || hs_max != 327) begin
            failures++;
            $display("FAIL hs_width got cnt=%0d span=%0d..%0d exp cnt=32 span=296..327",
                     hs_cnt, hs_min, hs_max);
        end
    endtask

    task automatic test_v_frame();
        bit prev_vs;
        int vs_cnt, lvbl_low, rise_v, rise_h, fall_v, fall_h;
        vs_cnt = 0; lvbl_low = 0; rise_v = -1; rise_h = -1; fall_v = -1; fall_h = -1;
        prev_vs = ifa.vs;
        ifa.pxl_cen = 1'b1;
        repeat (TA.ht * TA.vt) begin
            tick();
            checks++;
            if (get_a() !== model(TA, na)) begin
                failures++;
                $display("FAIL v_frame n=%0d got=%h exp=%h", na, get_a(), model(TA, na));
            end
            if (ifa.vs) vs_cnt++;
            if (!ifa.LVBL) lvbl_low++;
            if (!prev_vs && ifa.vs) begin rise_v = int'(ifa.V); rise_h = int'(ifa.H); end
            if (prev_vs && !ifa.vs) begin fall_v = int'(ifa.V); fall_h = int'(ifa.H); end
            prev_vs = ifa.vs;
        end
        ifa.pxl_cen = 1'b0;
        checks++;
        if (vs_cnt != 80 || rise_v != 11 || rise_h != 31 || fall_v != 13 || fall_h != 31) begin
            failures++;
            $display("FAIL vs_window got cnt=%0d rise=(%0d,%0d) fall=(%0d,%0d) exp 80 (11,31) (13,31)",
                     vs_cnt, rise_v, rise_h, fall_v, fall_h);
        end
        // Blank lines 10..13 and 0..1 -> 6 lines of 40 pixels
        checks++;
        if (lvbl_low != 240) begin
            failures++;
            $display("FAIL lvbl_low got=%0d exp=240", lvbl_low);
        end
    endtask

    task automatic test_strobes();
        int since_v, since_h, vinit_seen, toggles;
        bit have_h, prev_field;
        since_v = 0; since_h = 0; vinit_seen = 0; toggles = 0; have_h = 1'b0;
        prev_field = ifa.field;
        ifa.pxl_cen = 1'b1;
        repeat (2 * TA.ht * TA.vt) begin
            tick();
            since_v++;
            since_h++;
            if (ifa.field !== prev_field) toggles++;
            prev_field = ifa.field;
            if (ifa.hinit) begin
                if (have_h) begin
                    checks++;
                    if (since_h != TA.ht) begin
                        failures++;
                        $display("FAIL hinit_period got=%0d exp=%0d", since_h, TA.ht);
                    end
                end
                have_h = 1'b1;
                since_h = 0;
            end
            if (ifa.vinit) begin
                checks++;
                if (!ifa.hinit || ifa.V !== 4'd0 || ifa.H !== 6'd0) begin
                    failures++;
                    $display("FAIL vinit_pos got H=%0d V=%0d hinit=%b exp H=0 V=0 hinit=1",
                             ifa.H, ifa.V, ifa.hinit);
                end
                if (vinit_seen > 0) begin
                    checks++;
                    if (since_v != TA.ht * TA.vt) begin
                        failures++;
                        $display("FAIL vinit_period got=%0d exp=%0d", since_v, TA.ht * TA.vt);
                    end
                end
                vinit_seen++;
                since_v = 0;
            end
        end
        ifa.pxl_cen = 1'b0;
        checks++;
        if (vinit_seen != 2 || toggles != 2) begin
            failures++;
            $display("FAIL field_toggle got vinits=%0d toggles=%0d exp 2 2", vinit_seen, toggles);
        end
    endtask

    task automatic test_enable_gating();
        int cens, since_h;
        bit have_h, c;
        cens = 0; since_h = 0; have_h = 1'b0;
        for (int i = 0; i < 450; i++) begin
            // Enable every 4th clk, with a 50-clk stall in the middle
            c = (i % 4 == 0) && !(i >= 200 && i < 250);
            ifa.pxl_cen = c;
            tick();
            checks++;
            if (get_a() !== model(TA, na)) begin
                failures++;
                $display("FAIL gating clk=%0d cen=%b got=%h exp=%h", i, c, get_a(), model(TA, na));
            end
            if (c) begin
                cens++;
                since_h++;
                if (ifa.hinit) begin
                    if (have_h) begin
                        checks++;
                        if (since_h != TA.ht) begin
                            failures++;
                            $display("FAIL gated_line got=%0d exp=%0d", since_h, TA.ht);
                        end
                    end
                    have_h = 1'b1;
                    since_h = 0;
                end
            end
        end
        ifa.pxl_cen = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int target;
        target = 100 * TB.ht + 200;
        ifb.pxl_cen = 1'b1;
        for (int i = 0; i < 60000 && nb < target; i++) tick();
        checks++;
        if (ifb.V !== 9'd100 || ifb.H !== 9'd200 || get_b() !== model(TB, nb)) begin
            failures++;
            $display("FAIL midframe_pos got=%h exp=%h", get_b(), model(TB, target));
        end
        rst_b = 1'b0;
        tick();
        checks++;
        if (get_b() !== RstObs) begin
            failures++;
            $display("FAIL midframe_reset got=%h exp=%h", get_b(), RstObs);
        end
        rst_b = 1'b1;
        tick();
        checks++;
        if (ifb.H !== 9'd1 || ifb.V !== 9'd0 || ifb.hinit !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got H=%0d V=%0d hinit=%b exp H=1 V=0 hinit=0",
                     ifb.H, ifb.V, ifb.hinit);
        end
        ifb.pxl_cen = 1'b0;
    endtask

    task automatic test_nonwrap();
        int low_cnt, low_min, low_max, vs_cnt;
        low_cnt = 0; low_min = 9999; low_max = -1; vs_cnt = 0;
        ifc.pxl_cen = 1'b1;
        repeat (TC.ht * TC.vt) begin
            tick();
            checks++;
            if (get_c() !== model(TC, nc)) begin
                failures++;
                $display("FAIL nonwrap n=%0d got=%h exp=%h", nc, get_c(), model(TC, nc));
            end
            if (!ifc.LHBL) begin
                low_cnt++;
                if (int'(ifc.H) < low_min) low_min = int'(ifc.H);
                if (int'(ifc.H) > low_max) low_max = int'(ifc.H);
            end
            if (ifc.vs) vs_cnt++;
        end
        ifc.pxl_cen = 1'b0;
        checks++;
        if (low_cnt != 32 * TC.vt || low_min != 8 || low_max != 39) begin
            failures++;
            $display("FAIL nonwrap_hb got cnt=%0d span=%0d..%0d exp cnt=%0d span=8..39",
                     low_cnt, low_min, low_max, 32 * TC.vt);
        end
        checks++;
        if (vs_cnt != 0) begin
            failures++;
            $display("FAIL vs_equal got high=%0d exp=0", vs_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ifa.pxl_cen = ($urandom_range(0, 1) == 1);
            rst_a = ($urandom_range(0, 199) != 0);
            tick();
            checks++;
            if (get_a() !== model(TA, na)) begin
                failures++;
                $display("FAIL random clk=%0d n=%0d got=%h exp=%h", i, na, get_a(), model(TA, na));
            end
        end
        rst_a = 1'b1;
        ifa.pxl_cen = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ifa.pxl_cen = 1'b0; ifb.pxl_cen = 1'b0; ifc.pxl_cen = 1'b0;
        #1;
        test_reset();
        test_h_line();
        test_v_frame();
        test_strobes();
        test_enable_gating();
        test_midframe_reset();
        test_nonwrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
